vc_mode_counter: RTL and testbench
==================================

VC_MODE_COUNTER -- requirements
Module: vc_ModeCounter

Interface
REQ-001 SHALL have parameter p_count_nbits, default 4, width of count and load_value.
REQ-002 SHALL have parameter p_count_reset_value, default 0, count value after reset or clear.
REQ-003 SHALL have parameter p_count_min_value, default 0, lower bound of count.
REQ-004 SHALL have parameter p_count_max_value, default 15, upper bound of count.
REQ-005 SHALL have parameter p_step_nbits, default 2, width of step.
REQ-006 SHALL have parameter p_wrap, default 0, mode select: 0 saturate, 1 wrap.
REQ-007 SHALL satisfy min <= reset_value <= max <= 2^p_count_nbits-1 and 2^p_step_nbits-1 <= max-min+1; elaboration SHALL fail otherwise.
REQ-008 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port clear, input, 1, synchronous return to reset value and clear of sticky flags.
REQ-011 SHALL have port load, input, 1, synchronous load of load_value.
REQ-012 SHALL have port load_value, input, p_count_nbits, value to load.
REQ-013 SHALL have port increment, input, 1, add step.
REQ-014 SHALL have port decrement, input, 1, subtract step.
REQ-015 SHALL have port step, input, p_step_nbits, amount per increment or decrement.
REQ-016 SHALL have port count, output, p_count_nbits, registered count.
REQ-017 SHALL have port count_is_min, output, 1, count == min.
REQ-018 SHALL have port count_is_max, output, 1, count == max.
REQ-019 SHALL have port overflow, output, 1, sticky: an increment exceeded max.
REQ-020 SHALL have port underflow, output, 1, sticky: a decrement went below min.

Function
REQ-021 count, overflow and underflow SHALL be registers; count_is_min and count_is_max SHALL be combinational from count.
REQ-022 Next-state priority SHALL be clear > load > increment/decrement.
REQ-023 clear SHALL set count = reset_value and overflow = underflow = 0 on the next edge.
REQ-024 load SHALL set count = load_value clamped to [min,max] on the next edge; load SHALL leave sticky flags unchanged.
REQ-025 increment and decrement together, or step == 0, SHALL leave count and flags unchanged.
REQ-026 All arithmetic SHALL use p_count_nbits+1 bits internally so that no intermediate value aliases.
REQ-027 Increment with count+step <= max SHALL give count+step; decrement with count-step >= min SHALL give count-step.
REQ-028 Saturate mode (p_wrap=0): count+step > max SHALL give max; count-step < min SHALL give min.
REQ-029 Wrap mode (p_wrap=1), R = max-min+1: count+step > max SHALL give count+step-R; count-step < min SHALL give count-step+R.
REQ-030 In either mode, crossing above max SHALL set overflow and crossing below min SHALL set underflow; both SHALL hold until clear or reset.
REQ-031 Landing exactly on max or min SHALL NOT set a sticky flag.
REQ-032 With no operation asserted, count and flags SHALL hold.
REQ-033 Inputs SHALL be sampled only at the rising clk edge; outputs SHALL change only after an edge or on reset.

Reset
REQ-034 Asserting reset SHALL immediately, without waiting for clk, set count = reset_value and overflow = underflow = 0.
REQ-035 While reset is high, all other inputs SHALL be ignored.
REQ-036 The first edge after reset deasserts SHALL process inputs normally.

Verification
Bench parameters: nbits 4, min 2, max 9, reset_value 5, step_nbits 2.
REQ-037 Saturate mode: reset, then increment step 3 for 2 cycles -> count 8, then 9 (is_max=1, overflow=1); one more increment -> 9, overflow stays 1.
REQ-038 Wrap mode: from 8, increment step 3 -> 3 (overflow=1); clear -> 5, flags 0; from 3, decrement step 3 -> 8 (underflow=1).
REQ-039 load_value 12 -> count 9; load_value 0 -> count 2 (is_min=1); load with increment high -> loaded value wins, flags unchanged.
REQ-040 From 5: increment+decrement with step 3 -> 5; step 0 with increment -> 5; decrement step 3 -> 2, exactly at min -> underflow=0.
REQ-041 Reset asserted mid-cycle at count 7 with overflow=1 -> count 5 and flags 0 before the next clk edge; the next edge with reset low and increment step 1 -> 6.

Source files
------------

// File: rtl/vc_mode_counter.sv
// Up/down counter with a runtime step, a saturate or wrap policy chosen at
// elaboration, a clamped synchronous load and sticky overflow/underflow flags.
module vc_mode_counter #(
   parameter int p_count_nbits       = 4,
   parameter int p_count_reset_value = 0,
   parameter int p_count_min_value   = 0,
   parameter int p_count_max_value   = 15,
   parameter int p_step_nbits        = 2,
   parameter int p_wrap              = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     load,
   input  logic [p_count_nbits-1:0] load_value,
   input  logic                     increment,
   input  logic                     decrement,
   input  logic [p_step_nbits-1:0]  step,
   output logic [p_count_nbits-1:0] count,
   output logic                     count_is_min,
   output logic                     count_is_max,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int W = p_count_nbits + 1;
   typedef logic [W-1:0] wide_t;

   localparam wide_t MIN = wide_t'(p_count_min_value);
   localparam wide_t MAX = wide_t'(p_count_max_value);
   localparam wide_t RST = wide_t'(p_count_reset_value);
   localparam wide_t RNG = wide_t'(p_count_max_value - p_count_min_value + 1);

   if (!(p_count_min_value <= p_count_reset_value &&
         p_count_reset_value <= p_count_max_value &&
         p_count_max_value <= (1 << p_count_nbits) - 1 &&
         (1 << p_step_nbits) - 1 <= p_count_max_value - p_count_min_value + 1)) begin : g_bad_params
      $error("vc_mode_counter: inconsistent parameters");
   end

   logic [p_count_nbits-1:0] count_q, count_d;
   logic                     ovf_q, ovf_d;
   logic                     udf_q, udf_d;

   wide_t cnt_w, step_w, lv_w, up_w, up_wrap_w, dn_w, dn_wrap_w;
   logic  up_over, dn_under;

   // One extra bit keeps sums and the min+step bound from aliasing; the
   // wrapped decrement adds the range before subtracting so it never goes negative.
   always_comb begin
      cnt_w     = {1'b0, count_q};
      step_w    = wide_t'(step);
      lv_w      = {1'b0, load_value};
      up_w      = cnt_w + step_w;
      up_wrap_w = up_w - RNG;
      dn_w      = cnt_w - step_w;
      dn_wrap_w = cnt_w + RNG - step_w;
      up_over   = up_w > MAX;
      dn_under  = cnt_w < (MIN + step_w);

      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;

      if (clear) begin
         count_d = RST[p_count_nbits-1:0];
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else if (load) begin
         if (lv_w < MIN)      count_d = MIN[p_count_nbits-1:0];
         else if (lv_w > MAX) count_d = MAX[p_count_nbits-1:0];
         else                 count_d = load_value;
      end else if ((increment ^ decrement) && (step != '0)) begin
         if (increment) begin
            if (up_over) begin
               ovf_d   = 1'b1;
               count_d = (p_wrap != 0) ? up_wrap_w[p_count_nbits-1:0] : MAX[p_count_nbits-1:0];
            end else begin
               count_d = up_w[p_count_nbits-1:0];
            end
         end else begin
            if (dn_under) begin
               udf_d   = 1'b1;
               count_d = (p_wrap != 0) ? dn_wrap_w[p_count_nbits-1:0] : MIN[p_count_nbits-1:0];
            end else begin
               count_d = dn_w[p_count_nbits-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= RST[p_count_nbits-1:0];
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign count_is_min = ({1'b0, count_q} == MIN);
   assign count_is_max = ({1'b0, count_q} == MAX);

endmodule

// File: tb/tb_vc_mode_counter.sv
// Directed bench: a saturating and a wrapping counter (min 2, max 9, reset 5)
// share one stimulus stream; expected values are hand-computed.
module tb_vc_mode_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0, load = 1'b0, increment = 1'b0, decrement = 1'b0;
   logic [3:0] load_value = '0;
   logic [1:0] step = '0;

   logic [3:0] cnt_s, cnt_w;
   logic       min_s, max_s, ovf_s, udf_s;
   logic       min_w, max_w, ovf_w, udf_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vc_mode_counter #(.p_count_nbits(4), .p_count_reset_value(5), .p_count_min_value(2),
                     .p_count_max_value(9), .p_step_nbits(2), .p_wrap(0)) u_sat (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .increment(increment), .decrement(decrement), .step(step),
      .count(cnt_s), .count_is_min(min_s), .count_is_max(max_s),
      .overflow(ovf_s), .underflow(udf_s));

   vc_mode_counter #(.p_count_nbits(4), .p_count_reset_value(5), .p_count_min_value(2),
                     .p_count_max_value(9), .p_step_nbits(2), .p_wrap(1)) u_wrap (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .increment(increment), .decrement(decrement), .step(step),
      .count(cnt_w), .count_is_min(min_w), .count_is_max(max_w),
      .overflow(ovf_w), .underflow(udf_w));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // count, is_min, is_max, overflow, underflow for each instance
   task automatic chk_s(input string tag, input int c, input int mn, input int mx, input int o, input int u);
      chk({tag, ".s.cnt"}, cnt_s, c);
      chk({tag, ".s.min"}, min_s, mn);
      chk({tag, ".s.max"}, max_s, mx);
      chk({tag, ".s.ovf"}, ovf_s, o);
      chk({tag, ".s.udf"}, udf_s, u);
   endtask

   task automatic chk_w(input string tag, input int c, input int o, input int u);
      chk({tag, ".w.cnt"}, cnt_w, c);
      chk({tag, ".w.ovf"}, ovf_w, o);
      chk({tag, ".w.udf"}, udf_w, u);
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic c, input logic l, input logic [3:0] lv,
                      input logic i, input logic d, input logic [1:0] s);
      clear = c; load = l; load_value = lv; increment = i; decrement = d; step = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      chk_s("rst", 5, 0, 0, 0, 0);
      chk_w("rst", 5, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      cyc(0, 0, 0, 1, 0, 3);  chk_s("inc1", 8, 0, 0, 0, 0); chk_w("inc1", 8, 0, 0);
      cyc(0, 0, 0, 1, 0, 3);  chk_s("inc2", 9, 0, 1, 1, 0); chk_w("inc2", 3, 1, 0);
      cyc(0, 0, 0, 1, 0, 3);  chk_s("inc3", 9, 0, 1, 1, 0); chk_w("inc3", 6, 1, 0);
      cyc(0, 0, 0, 0, 0, 3);  chk_s("idle", 9, 0, 1, 1, 0); chk_w("idle", 6, 1, 0);
      cyc(1, 1, 7, 1, 0, 3);  chk_s("clr",  5, 0, 0, 0, 0); chk_w("clr",  5, 0, 0);
      cyc(0, 1, 3, 0, 0, 0);  chk_s("ld3",  3, 0, 0, 0, 0); chk_w("ld3",  3, 0, 0);
      cyc(0, 0, 0, 0, 1, 3);  chk_s("dec",  2, 1, 0, 0, 1); chk_w("dec",  8, 0, 1);
      cyc(0, 1, 12, 0, 0, 0); chk_s("ld12", 9, 0, 1, 0, 1); chk_w("ld12", 9, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);  chk_s("ld0",  2, 1, 0, 0, 1); chk_w("ld0",  2, 0, 1);
      cyc(0, 1, 7, 1, 0, 3);  chk_s("ldinc", 7, 0, 0, 0, 1); chk_w("ldinc", 7, 0, 1);

      cyc(1, 0, 0, 0, 0, 0);  chk_s("clr2", 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 3);  chk_s("both", 5, 0, 0, 0, 0); chk_w("both", 5, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);  chk_s("step0", 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 3);  chk_s("atmin", 2, 1, 0, 0, 0); chk_w("atmin", 2, 0, 0);

      cyc(0, 0, 0, 1, 0, 3);  chk_s("up5", 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 3);  chk_s("up8", 8, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 3);  chk_s("up9", 9, 0, 1, 1, 0); chk_w("up9", 3, 1, 0);
      cyc(0, 1, 7, 0, 0, 0);  chk_s("ld7", 7, 0, 0, 1, 0); chk_w("ld7", 7, 1, 0);

      // Asynchronous reset mid-cycle with an increment pending
      #2;
      reset = 1'b1; load = 1'b0; increment = 1'b1; step = 2'd1;
      #1;
      chk_s("arst", 5, 0, 0, 0, 0);
      chk_w("arst", 5, 0, 0);
      @(posedge clk);
      #1;
      chk_s("rsthold", 5, 0, 0, 0, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_s("post", 6, 0, 0, 0, 0);
      chk_w("post", 6, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
